uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg.sv | 212 +++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a small write FIFO in front of the serializer.
// Frames are start, DATA_BITS data bits LSB first, optional parity, and STOP_BITS stop bits.
module uart_tx_cfg #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                i_uart_clk,
  input  logic                                i_reset,
  input  logic [7:0]                          i_data,
  input  logic                                i_data_w,
  input  logic                                i_ovf_clr,
  output logic                                o_uart_tx,
  output logic                                o_full,
  output logic                                o_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     o_count,
  output logic                                o_busy,
  output logic                                o_overflow
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_DATA    = 3'(DATA_BITS - 1);
  localparam logic [2:0]    LAST_STOP    = 3'(STOP_BITS - 1);
  localparam logic [7:0]    DATA_MASK    = 8'((1 << DATA_BITS) - 1);
  localparam logic [CW-1:0] DEPTH_C      = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr    = '0;
  logic [PW-1:0] rd_ptr    = '0;
  logic [CW-1:0] count     = '0;
  logic          overflow  = 1'b0;

  state_t        state     = ST_IDLE;
  logic [TW-1:0] bit_timer = '0;
  logic [2:0]    bit_cnt   = '0;
  logic [7:0]    shreg     = '0;
  logic          par_bit   = 1'b0;
  logic          tx        = 1'b1;
  logic          busy      = 1'b0;

  logic       full;
  logic       empty;
  logic       push;
  logic       drop;
  logic       bit_done;
  logic       frame_end;
  logic       pop;
  logic [7:0] head;
  logic       head_par;

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  // A full FIFO refuses writes even when the serializer pops on the same edge.
  assign push      = i_data_w && !full;
  assign drop      = i_data_w && full;
  assign bit_done  = (bit_timer == '0);
  assign frame_end = (state == ST_STOP) && bit_done && (bit_cnt == LAST_STOP);
  assign pop       = !empty && ((state == ST_IDLE) || frame_end);
  assign head      = mem[rd_ptr];
  assign head_par  = (PARITY == 1) ? ~(^(head & DATA_MASK)) : ^(head & DATA_MASK);

  always_ff @(posedge i_uart_clk) begin
    if (i_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= i_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      // A dropped write wins over a clear on the same edge.
      if (drop) begin
        overflow <= 1'b1;
      end else if (i_ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Serializer: the line value for the next bit is registered at each bit boundary.
  always_ff @(posedge i_uart_clk) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      bit_timer <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            state     <= ST_START;
            busy      <= 1'b1;
            tx        <= 1'b0;
            shreg     <= head;
            par_bit   <= head_par;
            bit_timer <= TIMER_RELOAD;
          end
        end

        ST_START: begin
          if (bit_done) begin
            state     <= ST_DATA;
            tx        <= shreg[0];
            shreg     <= {1'b0, shreg[7:1]};
            bit_cnt   <= '0;
            bit_timer <= TIMER_RELOAD;
          end else begin
            bit_timer <= bit_timer - TW'(1);
          end
        end

        ST_DATA: begin
          if (bit_done) begin
            bit_timer <= TIMER_RELOAD;
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                state <= ST_PARITY;
                tx    <= par_bit;
              end else begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end
            end else begin
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            bit_timer <= bit_timer - TW'(1);
          end
        end

        ST_PARITY: begin
          if (bit_done) begin
            state     <= ST_STOP;
            tx        <= 1'b1;
            bit_cnt   <= '0;
            bit_timer <= TIMER_RELOAD;
          end else begin
            bit_timer <= bit_timer - TW'(1);
          end
        end

        ST_STOP: begin
          if (bit_done) begin
            bit_timer <= TIMER_RELOAD;
            if (bit_cnt == LAST_STOP) begin
              bit_cnt <= '0;
              // A waiting entry starts its frame immediately, with no idle bit between.
              if (!empty) begin
                state   <= ST_START;
                tx      <= 1'b0;
                shreg   <= head;
                par_bit <= head_par;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            bit_timer <= bit_timer - TW'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  assign o_uart_tx  = tx;
  assign o_full     = full;
  assign o_empty    = empty;
  assign o_count    = count;
  assign o_busy     = busy;
  assign o_overflow = overflow;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: three instances cover default, 7-bit even parity
// with 4 clocks per bit, and odd parity with two stop bits.
module tb_uart_tx_cfg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] a_data = '0, b_data = '0, c_data = '0;
  logic a_w = 1'b0, b_w = 1'b0, c_w = 1'b0;
  logic a_clr = 1'b0, b_clr = 1'b0, c_clr = 1'b0;
  logic a_tx, a_full, a_empty, a_busy, a_ovf;
  logic b_tx, b_full, b_empty, b_busy, b_ovf;
  logic c_tx, c_full, c_empty, c_busy, c_ovf;
  logic [2:0] a_count, b_count, c_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] qc[$];

  uart_tx_cfg dut_a (
    .i_uart_clk(clk), .i_reset(rst), .i_data(a_data), .i_data_w(a_w), .i_ovf_clr(a_clr),
    .o_uart_tx(a_tx), .o_full(a_full), .o_empty(a_empty), .o_count(a_count),
    .o_busy(a_busy), .o_overflow(a_ovf)
  );

  uart_tx_cfg #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut_b (
    .i_uart_clk(clk), .i_reset(rst), .i_data(b_data), .i_data_w(b_w), .i_ovf_clr(b_clr),
    .o_uart_tx(b_tx), .o_full(b_full), .o_empty(b_empty), .o_count(b_count),
    .o_busy(b_busy), .o_overflow(b_ovf)
  );

  uart_tx_cfg #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .CLKS_PER_BIT(1), .FIFO_DEPTH(4)) dut_c (
    .i_uart_clk(clk), .i_reset(rst), .i_data(c_data), .i_data_w(c_w), .i_ovf_clr(c_clr),
    .o_uart_tx(c_tx), .o_full(c_full), .o_empty(c_empty), .o_count(c_count),
    .o_busy(c_busy), .o_overflow(c_ovf)
  );

  function automatic logic tx_of(input int sel);
    return (sel == 0) ? a_tx : (sel == 1) ? b_tx : c_tx;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? a_busy : (sel == 1) ? b_busy : c_busy;
  endfunction

  function automatic logic [7:0] status_of(input int sel);
    case (sel)
      0:       return {a_tx, a_full, a_empty, a_busy, a_ovf, a_count};
      1:       return {b_tx, b_full, b_empty, b_busy, b_ovf, b_count};
      default: return {c_tx, c_full, c_empty, c_busy, c_ovf, c_count};
    endcase
  endfunction

  // Reference line waveform: one entry per clock cycle of the frame.
  task automatic build_frame(input logic [7:0] d, input int db, input int par, input int sb,
                             input int cpb, output logic [127:0] v, output int len);
    logic p;
    logic b;
    int n;
    v = '1;
    n = 0;
    p = 1'b0;
    for (int k = 0; k < cpb; k++) begin v[n] = 1'b0; n++; end
    for (int i = 0; i < db; i++) begin
      p = p ^ d[i];
      for (int k = 0; k < cpb; k++) begin v[n] = d[i]; n++; end
    end
    if (par != 0) begin
      b = (par == 1) ? ~p : p;
      for (int k = 0; k < cpb; k++) begin v[n] = b; n++; end
    end
    for (int s = 0; s < sb * cpb; s++) begin v[n] = 1'b1; n++; end
    len = n;
  endtask

  function automatic logic [127:0] ones(input int len);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < len; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic write_byte(input int sel, input logic [7:0] d, input logic clr);
    case (sel)
      0:       begin a_data = d; a_w = 1'b1; a_clr = clr; end
      1:       begin b_data = d; b_w = 1'b1; b_clr = clr; end
      default: begin c_data = d; c_w = 1'b1; c_clr = clr; end
    endcase
    @(posedge clk);
    #1;
    a_w = 1'b0; a_clr = 1'b0;
    b_w = 1'b0; b_clr = 1'b0;
    c_w = 1'b0; c_clr = 1'b0;
  endtask

  // Waits (bounded) for a start bit, then records len cycles of line and busy.
  task automatic recv(input int sel, input int len, output logic [127:0] txv,
                      output logic [127:0] busyv, output int gap, output bit timeout);
    timeout = 1'b0;
    gap     = 0;
    txv     = '1;
    busyv   = '0;
    @(negedge clk);
    while (tx_of(sel) !== 1'b0) begin
      gap++;
      if (gap > 200) begin
        timeout = 1'b1;
        return;
      end
      @(negedge clk);
    end
    txv[0]   = 1'b0;
    busyv[0] = busy_of(sel);
    for (int i = 1; i < len; i++) begin
      @(negedge clk);
      txv[i]   = tx_of(sel);
      busyv[i] = busy_of(sel);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      total++;
      if (status_of(s) !== 8'b1010_0000) begin
        bad++;
        $display("[TB] FAIL reset_status dut%0d: got %b want %b", s, status_of(s), 8'b1010_0000);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single_frame(input int sel, input logic [7:0] d, input int db,
                                   input int par, input int sb, input int cpb, input string nm);
    logic [127:0] txv, busyv, v;
    logic [7:0] exp_d;
    int gap, len;
    bit to;
    case (sel)
      0:       qa.push_back(d);
      1:       qb.push_back(d);
      default: qc.push_back(d);
    endcase
    write_byte(sel, d, 1'b0);
    recv(sel, (1 + db + (par != 0 ? 1 : 0) + sb) * cpb, txv, busyv, gap, to);
    case (sel)
      0:       exp_d = qa.pop_front();
      1:       exp_d = qb.pop_front();
      default: exp_d = qc.pop_front();
    endcase
    build_frame(exp_d, db, par, sb, cpb, v, len);
    total++;
    if (to !== 1'b0) begin bad++; $display("[TB] FAIL %s_timeout: got %b want 0", nm, to); end
    total++;
    if (gap !== 1) begin bad++; $display("[TB] FAIL %s_latency: got %0d want 1", nm, gap); end
    total++;
    if (txv !== v) begin bad++; $display("[TB] FAIL %s_frame: got %h want %h", nm, txv, v); end
    total++;
    if (busyv !== ones(len)) begin
      bad++;
      $display("[TB] FAIL %s_busy: got %h want %h", nm, busyv, ones(len));
    end
    @(negedge clk);
    total++;
    if (tx_of(sel) !== 1'b1) begin bad++; $display("[TB] FAIL %s_idle_tx: got %b want 1", nm, tx_of(sel)); end
    total++;
    if (busy_of(sel) !== 1'b0) begin bad++; $display("[TB] FAIL %s_idle_busy: got %b want 0", nm, busy_of(sel)); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_a5();
    test_single_frame(0, 8'hA5, 8, 0, 1, 1, "a5");
    total++;
    if (a_empty !== 1'b1) begin bad++; $display("[TB] FAIL a5_empty: got %b want 1", a_empty); end
  endtask

  task automatic test_even_parity_7bit();
    test_single_frame(1, 8'h07, 7, 2, 1, 4, "even7");
  endtask

  task automatic test_odd_two_stop();
    test_single_frame(2, 8'h00, 8, 1, 2, 1, "odd2stop");
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [5] = '{8'h11, 8'h22, 8'h3C, 8'hF0, 8'h81};
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          qa.push_back(bytes[i]);
          write_byte(0, bytes[i], 1'b0);
        end
        @(negedge clk);
        total++;
        if (a_count !== 3'd4) begin bad++; $display("[TB] FAIL b2b_count: got %0d want 4", a_count); end
        total++;
        if (a_ovf !== 1'b0) begin bad++; $display("[TB] FAIL b2b_no_ovf: got %b want 0", a_ovf); end
        total++;
        if (a_full !== 1'b1) begin bad++; $display("[TB] FAIL b2b_full: got %b want 1", a_full); end
        @(posedge clk);
        #1;
        write_byte(0, 8'h99, 1'b1);
        @(negedge clk);
        total++;
        if (a_ovf !== 1'b1) begin bad++; $display("[TB] FAIL ovf_set_wins: got %b want 1", a_ovf); end
        total++;
        if (a_count !== 3'd4) begin bad++; $display("[TB] FAIL drop_count: got %0d want 4", a_count); end
        @(posedge clk);
        #1 a_clr = 1'b1;
        @(posedge clk);
        #1 a_clr = 1'b0;
        @(negedge clk);
        total++;
        if (a_ovf !== 1'b0) begin bad++; $display("[TB] FAIL ovf_clear: got %b want 0", a_ovf); end
      end
      begin
        logic [127:0] txv, busyv, v;
        logic [7:0] exp_d;
        int gap, len;
        bit to;
        for (int f = 0; f < 5; f++) begin
          recv(0, 10, txv, busyv, gap, to);
          exp_d = qa.pop_front();
          build_frame(exp_d, 8, 0, 1, 1, v, len);
          total++;
          if (to !== 1'b0) begin bad++; $display("[TB] FAIL b2b_timeout%0d: got %b want 0", f, to); end
          if (f > 0) begin
            total++;
            if (gap !== 0) begin bad++; $display("[TB] FAIL b2b_gap%0d: got %0d want 0", f, gap); end
          end
          total++;
          if (txv !== v) begin bad++; $display("[TB] FAIL b2b_frame%0d: got %h want %h", f, txv, v); end
        end
      end
    join
    @(negedge clk);
    total++;
    if (a_busy !== 1'b0 || a_empty !== 1'b1) begin
      bad++;
      $display("[TB] FAIL b2b_end: got busy=%b empty=%b want busy=0 empty=1", a_busy, a_empty);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d1 = 8'h5A;
    int active;
    qa.push_back(d1);
    write_byte(0, d1, 1'b0);
    qa.push_back(8'hC3);
    write_byte(0, 8'hC3, 1'b0);
    qa.push_back(8'hE7);
    write_byte(0, 8'hE7, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b1;
    a_w    = 1'b1;
    a_data = 8'hFF;
    @(negedge clk);
    total++;
    if (a_tx !== d1[3]) begin bad++; $display("[TB] FAIL mid_bit3: got %b want %b", a_tx, d1[3]); end
    total++;
    if (a_count !== 3'd2) begin bad++; $display("[TB] FAIL mid_queued: got %0d want 2", a_count); end
    @(negedge clk);
    qa.delete();
    total++;
    if (a_tx !== 1'b1) begin bad++; $display("[TB] FAIL mid_reset_tx: got %b want 1", a_tx); end
    total++;
    if (a_count !== 3'd0) begin bad++; $display("[TB] FAIL mid_reset_count: got %0d want 0", a_count); end
    total++;
    if (a_busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_busy: got %b want 0", a_busy); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_w = 1'b0;
    active = 0;
    repeat (40) begin
      @(negedge clk);
      if (a_tx !== 1'b1 || a_busy !== 1'b0) active++;
    end
    total++;
    if (active !== qa.size()) begin
      bad++;
      $display("[TB] FAIL mid_no_frames: got %0d active cycles want %0d", active, qa.size());
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_a5();
    test_even_parity_7bit();
    test_odd_two_stop();
    test_back_to_back();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
